// File: rtl/m_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, reads instruction memory over req/ack
// and queues {pc, inst} pairs for decode. Optional macro FETCH_PERF_EN adds a bubble counter.
module m_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     w_clk,
  input  logic                     w_rst,
  output logic                     w_imem_req,
  output logic [31:0]              w_imem_adr,
  input  logic                     w_imem_ack,
  input  logic [31:0]              w_imem_rdata,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic [31:0]              w_inst,
  output logic [31:0]              w_inst_pc,
  input  logic                     w_redir,
  input  logic [31:0]              w_redir_pc,
  output logic [$clog2(DEPTH):0]   w_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              w_bubble_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   stale_q, stale_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_inst [DEPTH];

  logic ack, push, pop;

  assign w_imem_req = (state_q != S_IDLE);
  // A dropped request keeps presenting its original address until the memory acks it.
  assign w_imem_adr = (state_q == S_DROP) ? stale_q : fpc_q;
  assign w_valid    = (count_q != '0);
  assign w_count    = count_q;
  assign w_inst     = w_valid ? mem_inst[rd_ptr_q] : 32'h0;
  assign w_inst_pc  = w_valid ? mem_pc[rd_ptr_q]   : 32'h0;

  assign ack  = w_imem_req & w_imem_ack;
  assign push = (state_q == S_REQ) & ack & ~w_redir;
  assign pop  = w_valid & w_ready & ~w_redir;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    fpc_d    = fpc_q;
    stale_d  = stale_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      fpc_d    = fpc_q + 32'd4;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);

    if (w_redir) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fpc_d    = w_redir_pc & ~32'd3;
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (ack) state_d = S_REQ;
          else begin
            state_d = S_DROP;
            stale_d = fpc_q;
          end
        end
        S_DROP:  state_d = ack ? S_REQ : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE:  state_d = (count_d < FULL) ? S_REQ : S_IDLE;
        S_REQ:   state_d = (ack && count_d == FULL) ? S_IDLE : S_REQ;
        S_DROP:  state_d = ack ? S_REQ : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q  <= S_IDLE;
      fpc_q    <= RESET_PC;
      stale_q  <= 32'h0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      stale_q  <= stale_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: queue storage has no reset; count and pointers decide which entries are meaningful.
  always_ff @(posedge w_clk) begin
    if (push) begin
      mem_pc[wr_ptr_q]   <= fpc_q;
      mem_inst[wr_ptr_q] <= w_imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] bubble_q, bubble_d;

  assign w_bubble_cnt = bubble_q;

  always_comb begin
    bubble_d = bubble_q;
    if (w_ready && !w_valid) bubble_d = bubble_q + 32'd1;
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) bubble_q <= 32'h0;
    else       bubble_q <= bubble_d;
  end
`endif

endmodule
